// File: rtl/multicycle_add_sub_nb_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_add_sub_nb_pkg
//   Shared definitions for the chunked add/subtract unit:
//     - state_e      : FSM state encoding (IDLE / RUN / DONE)
//     - calc_nchunk  : number of chunks an operand is split into
//     - idx_width    : width of the chunk index register (at least 1 bit)
// ----------------------------------------------------------------------------
package multicycle_add_sub_nb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Guarded against a zero chunk width so elaboration reaches the
    // explicit parameter check in the top level instead of dividing by zero.
    function automatic int calc_nchunk(input int adder_width, input int chunk_width);
        if (chunk_width < 1) begin
            return 1;
        end
        return adder_width / chunk_width;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        if (nchunk <= 1) begin
            return 1;
        end
        return $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// ----------------------------------------------------------------------------
// chunk_adder
//   Combinational WIDTH-bit ripple adder built from full_adder cells.
//   Ports: a, b   - chunk operands
//          c_in   - carry into bit 0
//          sum    - chunk sum (modulo 2^WIDTH)
//          c_out  - carry out of the top bit
//          c_msb  - carry into the top bit (used for signed overflow)
// ----------------------------------------------------------------------------
module chunk_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out.
    logic [WIDTH:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign c_out = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell.
//   Ports: a, b  - addend bits
//          ci    - carry in
//          s     - sum bit
//          co    - carry out
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/multicycle_add_sub_nb.sv
// ----------------------------------------------------------------------------
// multicycle_add_sub_nb
//   Sequential add/subtract unit. An ADDER_WIDTH-bit operation is processed
//   CHUNK_WIDTH bits per clock, LSB chunk first, with a registered carry
//   linking consecutive chunks.
//
//   Handshake: iStart is accepted in IDLE or DONE. oBusy is high for the
//   NCHUNK cycles in which chunks are processed; oDone pulses for one cycle
//   when oSum/oCarry/oOverflow are valid. Results hold until the next
//   accepted start clears them. iStart while busy is ignored.
//
//   Ports:
//     iClk, iRst      - clock (rising edge), synchronous active-high reset
//     iStart, iSub    - start request, 0 = add / 1 = subtract
//     iA, iB, iCarry  - operands and carry-in (carry-in ignored on subtract)
//     oSum            - result
//     oCarry          - carry out (subtract: 1 = no borrow)
//     oOverflow       - two's-complement overflow
//     oBusy, oDone    - status
//     oState          - current FSM state (state_e encoding), for debug
// ----------------------------------------------------------------------------
module multicycle_add_sub_nb
    import multicycle_add_sub_nb_pkg::*;
#(
    parameter int ADDER_WIDTH = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic                   iSub,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iCarry,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oCarry,
    output logic                   oOverflow,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [1:0]             oState
);

    localparam int NCHUNK = calc_nchunk(ADDER_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK_WIDTH < 1) begin : g_bad_chunk
        $error("multicycle_add_sub_nb: CHUNK_WIDTH must be at least 1");
    end else if ((ADDER_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_ratio
        $error("multicycle_add_sub_nb: ADDER_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [ADDER_WIDTH-1:0] a_q,         a_d;
    logic [ADDER_WIDTH-1:0] b_q,         b_d;     // holds ~B on subtract
    logic                   carry_q,     carry_d; // inter-chunk carry
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [ADDER_WIDTH-1:0] sum_q,       sum_d;
    logic                   carry_out_q, carry_out_d;
    logic                   ovf_q,       ovf_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    // ------------------------------------------------------------------
    // Current chunk
    // ------------------------------------------------------------------
    logic [CHUNK_WIDTH-1:0] chunk_a;
    logic [CHUNK_WIDTH-1:0] chunk_b;
    logic [CHUNK_WIDTH-1:0] chunk_sum;
    logic                   chunk_cout;
    logic                   chunk_cmsb;

    assign chunk_a = a_q[idx_q * CHUNK_WIDTH +: CHUNK_WIDTH];
    assign chunk_b = b_q[idx_q * CHUNK_WIDTH +: CHUNK_WIDTH];

    chunk_adder #(
        .WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a     (chunk_a),
        .b     (chunk_b),
        .c_in  (carry_q),
        .sum   (chunk_sum),
        .c_out (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    // Subtract is folded into the add path as A + ~B + 1.
                    a_d         = iA;
                    b_d         = iSub ? ~iB : iB;
                    carry_d     = iSub ? 1'b1 : iCarry;
                    idx_d       = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    ovf_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                sum_d[idx_q * CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    // Top chunk: its carries into/out of bit CW-1 are the
                    // carries into/out of the operand MSB.
                    carry_out_d = chunk_cout;
                    ovf_d       = chunk_cmsb ^ chunk_cout;
                    idx_d       = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign oSum      = sum_q;
    assign oCarry    = carry_out_q;
    assign oOverflow = ovf_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oState    = state_q;

endmodule

// File: tb/tb_multicycle_add_sub_nb.sv
// ----------------------------------------------------------------------------
// tb_multicycle_add_sub_nb
//   Bench for multicycle_add_sub_nb: a 16/4 instance for the main sequence
//   and an 8/8 instance for the single-chunk case. Expected results come from
//   a full-width arithmetic model and are queued when an operation is started.
// ----------------------------------------------------------------------------
module tb_multicycle_add_sub_nb;
    import multicycle_add_sub_nb_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // 16-bit / 4-bit-chunk instance
    // ------------------------------------------------------------------
    logic        s16_start, s16_sub, s16_cin;
    logic [15:0] s16_a, s16_b;
    logic [15:0] o16_sum;
    logic        o16_carry, o16_ovf, o16_busy, o16_done;
    logic [1:0]  o16_state;

    multicycle_add_sub_nb #(
        .ADDER_WIDTH (16),
        .CHUNK_WIDTH (4)
    ) dut16 (
        .iClk      (clk),
        .iRst      (rst),
        .iStart    (s16_start),
        .iSub      (s16_sub),
        .iA        (s16_a),
        .iB        (s16_b),
        .iCarry    (s16_cin),
        .oSum      (o16_sum),
        .oCarry    (o16_carry),
        .oOverflow (o16_ovf),
        .oBusy     (o16_busy),
        .oDone     (o16_done),
        .oState    (o16_state)
    );

    // ------------------------------------------------------------------
    // 8-bit single-chunk instance
    // ------------------------------------------------------------------
    logic        s8_start, s8_sub, s8_cin;
    logic [7:0]  s8_a, s8_b;
    logic [7:0]  o8_sum;
    logic        o8_carry, o8_ovf, o8_busy, o8_done;
    logic [1:0]  o8_state;

    multicycle_add_sub_nb #(
        .ADDER_WIDTH (8),
        .CHUNK_WIDTH (8)
    ) dut8 (
        .iClk      (clk),
        .iRst      (rst),
        .iStart    (s8_start),
        .iSub      (s8_sub),
        .iA        (s8_a),
        .iB        (s8_b),
        .iCarry    (s8_cin),
        .oSum      (o8_sum),
        .oCarry    (o8_carry),
        .oOverflow (o8_ovf),
        .oBusy     (o8_busy),
        .oDone     (o8_done),
        .oState    (o8_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard: {overflow, carry, sum[15:0]}
    // ------------------------------------------------------------------
    logic [17:0] exp_q[$];
    int passes = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain full-width arithmetic, overflow from operand/result signs.
    function automatic logic [17:0] model16(input logic sub, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ovf, full[16], full[15:0]};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks (16-bit instance)
    // ------------------------------------------------------------------
    task automatic drive16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input bit push);
        s16_sub   = sub;
        s16_a     = a;
        s16_b     = b;
        s16_cin   = cin;
        s16_start = 1'b1;
        if (push) exp_q.push_back(model16(sub, a, b, cin));
    endtask

    // Lets the start be sampled (edge t), then releases it.
    task automatic launch16();
        @(posedge clk);
        #1;
        s16_start = 1'b0;
    endtask

    // Called #1 after edge t. Latency is counted in edges including edge t.
    // With poke set, a conflicting start is presented during RUN.
    task automatic wait16(input string tag, input bit poke);
        int          n;
        int          busy_cnt;
        bit          seen;
        logic [17:0] e;
        n = 1;
        busy_cnt = 0;
        seen = 0;
        while (!seen && n <= 20) begin
            if (o16_done) begin
                seen = 1;
            end else begin
                if (o16_busy) busy_cnt++;
                if (poke && n == 2) begin
                    s16_start = 1'b1;
                    s16_sub   = 1'b1;
                    s16_a     = 16'hDEAD;
                    s16_b     = 16'h1234;
                    s16_cin   = 1'b1;
                end else begin
                    s16_start = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
        end
        s16_start = 1'b0;
        check({tag, " latency"}, seen ? n : 0, 5);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " busy_at_done"}, {31'd0, o16_busy}, 0);
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " sum"}, {16'd0, o16_sum}, {16'd0, e[15:0]});
            check({tag, " carry"}, {31'd0, o16_carry}, {31'd0, e[16]});
            check({tag, " ovf"}, {31'd0, o16_ovf}, {31'd0, e[17]});
        end
    endtask

    task automatic op16(input string tag, input logic sub, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
        drive16(sub, a, b, cin, 1);
        launch16();
        wait16(tag, 0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passes, total);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n8;
        bit seen8;
        int done_cnt;

        rst       = 1'b1;
        s16_start = 1'b0; s16_sub = 1'b0; s16_cin = 1'b0; s16_a = '0; s16_b = '0;
        s8_start  = 1'b0; s8_sub  = 1'b0; s8_cin  = 1'b0; s8_a  = '0; s8_b  = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst sum16",   {16'd0, o16_sum}, 0);
        check("rst carry16", {31'd0, o16_carry}, 0);
        check("rst ovf16",   {31'd0, o16_ovf}, 0);
        check("rst busy16",  {31'd0, o16_busy}, 0);
        check("rst done16",  {31'd0, o16_done}, 0);
        check("rst state16", {30'd0, o16_state}, {30'd0, ST_IDLE});
        check("rst sum8",    {24'd0, o8_sum}, 0);
        check("rst done8",   {31'd0, o8_done}, 0);
        rst = 1'b0;

        // 1. Plain add, then done must be a single-cycle pulse with held result
        op16("t1 add", 1'b0, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        check("t1 done_pulse", {31'd0, o16_done}, 0);
        check("t1 state_idle", {30'd0, o16_state}, {30'd0, ST_IDLE});
        check("t1 sum_held",   {16'd0, o16_sum}, 32'h0100);

        // 2. Wrap-around and signed overflow on add
        op16("t2 wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        op16("t2 ovf",  1'b0, 16'h7FFF, 16'h0001, 1'b0);

        // 3. Subtract with carry-in that must be ignored
        op16("t3 borrow",  1'b1, 16'h0005, 16'h0007, 1'b1);
        op16("t3 sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b1);

        // 4. Start during RUN ignored; start in DONE cycle accepted
        drive16(1'b0, 16'h1111, 16'h2222, 1'b1, 1);
        launch16();
        wait16("t4 poke", 1);
        check("t4 state_done", {30'd0, o16_state}, {30'd0, ST_DONE});
        drive16(1'b1, 16'h3000, 16'h0123, 1'b0, 1);
        launch16();
        wait16("t4 b2b", 0);

        // 5. Reset in the 2nd RUN cycle aborts without a done
        drive16(1'b0, 16'h1234, 16'h4321, 1'b0, 0);
        launch16();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5 sum",   {16'd0, o16_sum}, 0);
        check("t5 carry", {31'd0, o16_carry}, 0);
        check("t5 ovf",   {31'd0, o16_ovf}, 0);
        check("t5 busy",  {31'd0, o16_busy}, 0);
        check("t5 done",  {31'd0, o16_done}, 0);
        check("t5 state", {30'd0, o16_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (o16_done) done_cnt++;
        end
        check("t5 no_done", done_cnt, 0);
        op16("t5 after", 1'b0, 16'h0F0F, 16'h00F1, 1'b1);

        // Random mix of adds and subtracts
        for (int i = 0; i < 6; i++) begin
            op16("rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        // 6. Single-chunk configuration: 0x80 + 0x80
        s8_a = 8'h80; s8_b = 8'h80; s8_sub = 1'b0; s8_cin = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1;
        s8_start = 1'b0;
        n8 = 1;
        seen8 = 0;
        while (!seen8 && n8 <= 10) begin
            if (o8_done) begin
                seen8 = 1;
            end else begin
                @(posedge clk);
                #1;
                n8++;
            end
        end
        check("t6 latency", seen8 ? n8 : 0, 2);
        check("t6 sum",   {24'd0, o8_sum}, 0);
        check("t6 carry", {31'd0, o8_carry}, 1);
        check("t6 ovf",   {31'd0, o8_ovf}, 1);

        check("queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
